// File: rtl/syndrome_frame_packer.sv
// Frames GRID_WIDTH_U syndrome rounds into a 32-bit word stream (header, then round words)
// for the decoder core, with frame sequencing, a synchronous flush/abort path and a busy flag.
module syndrome_frame_packer #(
   parameter int GRID_WIDTH_X = 12,
   parameter int GRID_WIDTH_Z = 2,
   parameter int GRID_WIDTH_U = 10
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] round_data,
   input  logic                                 round_valid,
   output logic                                 round_ready,
   input  logic                                 flush,
   output logic [31:0]                          out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [7:0]                           frame_seq,
   output logic                                 busy
);

   localparam int ROUND_BITS      = GRID_WIDTH_X * GRID_WIDTH_Z;
   localparam int WORDS_PER_ROUND = (ROUND_BITS + 31) / 32;
   localparam int BUF_W           = WORDS_PER_ROUND * 32;
   localparam int WIDX_W          = $clog2(WORDS_PER_ROUND) + 1;

   localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(WORDS_PER_ROUND - 1);
   localparam logic [15:0]       LAST_ROUND = 16'(GRID_WIDTH_U - 1);
   localparam logic [15:0]       ROUNDS_U16 = 16'(GRID_WIDTH_U);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HEADER = 2'd1;
   localparam logic [1:0] S_LOAD   = 2'd2;
   localparam logic [1:0] S_SEND   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              valid_q, valid_d;
   logic              rdy_q, rdy_d;
   logic [7:0]        seq_q, seq_d;
   logic [15:0]       round_idx_q, round_idx_d;
   logic [WIDX_W-1:0] word_idx_q, word_idx_d;
   logic [BUF_W-1:0]  buf_q, buf_d;

   // The presented word is always the low 32 bits of the buffer: the header is parked
   // there, and round words are shifted down so the zero-padded tail comes out last.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      rdy_d       = rdy_q;
      seq_d       = seq_q;
      round_idx_d = round_idx_q;
      word_idx_d  = word_idx_q;
      buf_d       = buf_q;
      if (flush) begin
         state_d     = S_IDLE;
         valid_d     = 1'b0;
         rdy_d       = 1'b0;
         round_idx_d = '0;
         word_idx_d  = '0;
         if (state_q != S_IDLE) seq_d = seq_q + 8'd1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (round_valid) begin
                  state_d = S_HEADER;
                  valid_d = 1'b1;
                  buf_d   = BUF_W'({8'hA5, seq_q, ROUNDS_U16});
               end
            end
            S_HEADER: begin
               if (out_ready) begin
                  state_d = S_LOAD;
                  valid_d = 1'b0;
                  rdy_d   = 1'b1;
               end
            end
            S_LOAD: begin
               if (round_valid) begin
                  state_d    = S_SEND;
                  rdy_d      = 1'b0;
                  valid_d    = 1'b1;
                  word_idx_d = '0;
                  buf_d      = BUF_W'(round_data);
               end
            end
            S_SEND: begin
               if (out_ready) begin
                  if (word_idx_q < LAST_WORD) begin
                     word_idx_d = word_idx_q + WIDX_W'(1);
                     buf_d      = buf_q >> 32;
                  end else begin
                     valid_d = 1'b0;
                     if (round_idx_q < LAST_ROUND) begin
                        round_idx_d = round_idx_q + 16'd1;
                        state_d     = S_LOAD;
                        rdy_d       = 1'b1;
                     end else begin
                        round_idx_d = '0;
                        seq_d       = seq_q + 8'd1;
                        state_d     = S_IDLE;
                     end
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               rdy_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         valid_q     <= 1'b0;
         rdy_q       <= 1'b0;
         seq_q       <= '0;
         round_idx_q <= '0;
         word_idx_q  <= '0;
         buf_q       <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         rdy_q       <= rdy_d;
         seq_q       <= seq_d;
         round_idx_q <= round_idx_d;
         word_idx_q  <= word_idx_d;
         buf_q       <= buf_d;
      end
   end

   assign out_data    = buf_q[31:0];
   assign out_valid   = valid_q;
   assign round_ready = rdy_q;
   assign frame_seq   = seq_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/syndrome_frame_packer.md
Name: syndrome_frame_packer

Overview:
- Upstream feeder for the single-FPGA decoder core.
- Accepts one measurement round per handshake, as a vector of GRID_WIDTH_X*GRID_WIDTH_Z syndrome bits.
- Frames GRID_WIDTH_U consecutive rounds into a 32-bit word stream (header, then round words) on a valid/ready interface that drives the core's input_data/input_valid/input_ready.
- Also provides frame sequencing, an abort path and status.

Parameters:
- GRID_WIDTH_X, 12, X width of the per-round PU grid.
- GRID_WIDTH_Z, 2, Z width of the per-round PU grid.
- GRID_WIDTH_U, 10, measurement rounds per frame (1..65535).
- Derived, not overridable:
  - ROUND_BITS = GRID_WIDTH_X*GRID_WIDTH_Z.
  - WORDS_PER_ROUND = (ROUND_BITS+31)/32.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- round_data  input  ROUND_BITS  syndrome bits of one round; bit i = PU i of the round.
- round_valid  input  1  round_data valid.
- round_ready  output  1  round accepted when round_valid & round_ready.
- flush  input  1  synchronous abort of the current frame.
- out_data  output  32  framed word to the decoder.
- out_valid  output  1  out_data valid.
- out_ready  input  1  decoder accepts word when out_valid & out_ready.
- frame_seq  output  8  sequence number of the next/current frame.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values (asynchronous, reset high):
  - State IDLE; out_valid=0; out_data=0; round_ready=0.
  - frame_seq=0, round_idx=0, word_idx=0, round buffer=0.
- Reset asserted mid-frame discards everything; no partial words are emitted after reset release.
- States: IDLE, HEADER, LOAD, SEND.
- IDLE:
  - round_ready=0.
  - If round_valid=1, go to HEADER next cycle.
  - out_valid rises in that same next cycle with out_data = {8'hA5, frame_seq, GRID_WIDTH_U[15:0]}.
- HEADER:
  - Hold out_valid=1 and out_data stable until out_ready.
  - On accept: out_valid=0, go to LOAD.
- LOAD:
  - round_ready=1; this is the only state where it is high. round_ready is a registered state decode, not combinational on round_valid.
  - On round_valid: capture round_data zero-padded to WORDS_PER_ROUND*32 bits, set word_idx=0, go to SEND.
  - out_valid rises the next cycle with word 0.
- SEND:
  - out_data = buffer bits [32*word_idx+31 : 32*word_idx]; unused high bits of the last word are 0.
  - out_data is stable while out_valid & !out_ready.
  - On each accept with word_idx<WORDS_PER_ROUND-1: increment word_idx and present the next word in the following cycle.
  - Back-to-back words are allowed, i.e. out_valid stays 1 when out_ready is continuously 1.
  - On accept of the last word:
    - If round_idx<GRID_WIDTH_U-1: round_idx++, out_valid=0, go to LOAD.
    - Else: round_idx=0, frame_seq++ (wraps 255->0), out_valid=0, go to IDLE.
- Throughput with out_ready tied high: one round per WORDS_PER_ROUND+1 cycles. A frame occupies 1 header word + GRID_WIDTH_U*WORDS_PER_ROUND data words.
- flush:
  - flush=1 in any state: next cycle state=IDLE, out_valid=0, round_ready=0, round_idx=0, word_idx=0.
  - frame_seq is incremented only if state was not IDLE; this lets the decoder detect the dropped frame.
  - flush has priority over a simultaneous out_ready or round_valid handshake in the same cycle. That handshake is ignored: the word counts as not delivered and the round as not taken.
- Any round_valid seen while not in LOAD is simply not accepted. No data is lost; the upstream producer holds it.
- busy = (state != IDLE).

Test Plan:
- Default params, out_ready=1, ten rounds presented with round_data = round index -> 11 words:
  - 0xA500000A;
  - then 0x00000000..0x00000009;
  - frame_seq ends at 1; busy low after the last word.
- GRID_WIDTH_X=20, Z=2 (40 bits, 2 words/round), U=2, rounds 0xAB_12345678 then 0xCD_9ABCDEF0 -> words:
  - 0xA5000002;
  - 0x12345678, 0x000000AB;
  - 0x9ABCDEF0, 0x000000CD.
- Backpressure: out_ready low for 5 cycles on the header and every 2nd data word -> out_data/out_valid stable throughout, sequence identical to the no-stall run, round_ready never high outside LOAD.
- flush asserted after 3 of 10 rounds with out_ready=1 in the same cycle -> that word not counted, IDLE next cycle, frame_seq=1. The next frame header is 0xA501000A.
- 256 complete frames -> frame_seq wraps to 0; the 257th header is 0xA500000A.
- Async reset pulsed mid-SEND, between clock edges -> out_valid/round_ready/busy drop immediately. After release, the first word emitted is a header with frame_seq=0.
